// File: rtl/fetch_arbiter.sv
// Round-robin arbiter that shares the single FETCH unit among four hardware threads,
// serialising their requests onto the f_enable/ack handshake with a timeout abort.
module fetch_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [3:0]   req_we,
    input  logic [127:0] req_addr,
    input  logic [127:0] req_wdata,
    output logic [3:0]   rsp_valid,
    output logic         rsp_err,
    output logic [31:0]  rsp_data,
    output logic         busy,
    output logic         f_enable,
    output logic         write_mode,
    output logic [31:0]  f_addr,
    output logic [31:0]  f_data_i,
    output logic [1:0]   f_thread,
    input  logic [31:0]  f_data_o,
    input  logic         f_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  g_q, g_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        busy_q, busy_d;
    logic        f_enable_q, f_enable_d;
    logic        write_mode_q, write_mode_d;
    logic [31:0] f_addr_q, f_addr_d;
    logic [31:0] f_data_i_q, f_data_i_d;
    logic [1:0]  f_thread_q, f_thread_d;

    logic        found;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic [7:0]  cnt_inc;
    logic        done;

    // Rotating priority: scan ptr+1, ptr+2, ... so the last winner goes to the back.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        f_enable_d   = f_enable_q;
        write_mode_d = write_mode_q;
        f_addr_d     = f_addr_q;
        f_data_i_d   = f_data_i_q;
        f_thread_d   = f_thread_q;
        cnt_inc      = cnt_q + 8'd1;
        done         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    g_d          = pick;
                    f_addr_d     = req_addr[32*pick +: 32];
                    f_data_i_d   = req_wdata[32*pick +: 32];
                    write_mode_d = req_we[pick];
                    f_thread_d   = pick;
                    f_enable_d   = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                // Ack is checked first so a coincident ack and timeout counts as success.
                if (f_ack) begin
                    rsp_data_d = f_data_o;
                    rsp_err_d  = 1'b0;
                    done       = 1'b1;
                end else if (cnt_inc == TO_CNT) begin
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b1;
                    done       = 1'b1;
                end
                if (done) begin
                    rsp_valid_d = 4'b0001 << g_q;
                    f_enable_d  = 1'b0;
                    ptr_d       = g_q;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rsp_valid_d = 4'b0000;
                if (!f_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            g_q          <= 2'd0;
            ptr_q        <= 2'd3;
            cnt_q        <= 8'd0;
            rsp_valid_q  <= 4'd0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= 32'd0;
            busy_q       <= 1'b0;
            f_enable_q   <= 1'b0;
            write_mode_q <= 1'b0;
            f_addr_q     <= 32'd0;
            f_data_i_q   <= 32'd0;
            f_thread_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
            f_enable_q   <= f_enable_d;
            write_mode_q <= write_mode_d;
            f_addr_q     <= f_addr_d;
            f_data_i_q   <= f_data_i_d;
            f_thread_q   <= f_thread_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign f_enable   = f_enable_q;
    assign write_mode = write_mode_q;
    assign f_addr     = f_addr_q;
    assign f_data_i   = f_data_i_q;
    assign f_thread   = f_thread_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed self-checking bench for fetch_arbiter with a small FETCH responder model
// whose ack latency, stickiness and silence are programmable per test.
module tb_fetch_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   rsp_valid;
    logic         rsp_err;
    logic [31:0]  rsp_data;
    logic         busy;
    logic         f_enable;
    logic         write_mode;
    logic [31:0]  f_addr;
    logic [31:0]  f_data_i;
    logic [1:0]   f_thread;
    logic [31:0]  f_data_o;
    logic         f_ack;

    int n_checks = 0;
    int n_err    = 0;

    logic        fetch_on;
    int          ack_lat;
    int          sticky_len;
    logic [31:0] fetch_rdata;
    int          en_cnt;
    int          hold_cnt;

    fetch_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .f_enable   (f_enable),
        .write_mode (write_mode),
        .f_addr     (f_addr),
        .f_data_i   (f_data_i),
        .f_thread   (f_thread),
        .f_data_o   (f_data_o),
        .f_ack      (f_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FETCH model: registered ack after ack_lat cycles of f_enable, held sticky_len extra cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_ack    <= 1'b0;
            f_data_o <= 32'd0;
            en_cnt   <= 0;
            hold_cnt <= 0;
        end else if (f_enable && fetch_on) begin
            en_cnt <= en_cnt + 1;
            if (en_cnt + 1 >= ack_lat) begin
                f_ack    <= 1'b1;
                f_data_o <= fetch_rdata;
                hold_cnt <= sticky_len;
            end
        end else begin
            en_cnt <= 0;
            if (f_ack) begin
                if (hold_cnt == 0) f_ack <= 1'b0;
                else               hold_cnt <= hold_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string p);
        check({p, "_rsp_valid"},  {28'd0, rsp_valid}, 32'd0);
        check({p, "_rsp_err"},    {31'd0, rsp_err},    32'd0);
        check({p, "_rsp_data"},   rsp_data,            32'd0);
        check({p, "_busy"},       {31'd0, busy},       32'd0);
        check({p, "_f_enable"},   {31'd0, f_enable},   32'd0);
        check({p, "_write_mode"}, {31'd0, write_mode}, 32'd0);
        check({p, "_f_addr"},     f_addr,              32'd0);
        check({p, "_f_data_i"},   f_data_i,            32'd0);
        check({p, "_f_thread"},   {30'd0, f_thread},   32'd0);
    endtask

    task automatic wait_grant(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (f_enable) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'd0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int cyc;
        int ack_cycles;
        int gap;

        rst_n       = 1'b0;
        req         = 4'd0;
        req_we      = 4'd0;
        req_addr    = '0;
        req_wdata   = '0;
        fetch_on    = 1'b1;
        ack_lat     = 1;
        sticky_len  = 0;
        fetch_rdata = 32'd0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req_busy", {31'd0, busy}, 32'd0);

        // Single read from thread 2
        req_addr[95:64] = 32'h1000_0003;
        fetch_rdata     = 32'h0000_00EA;
        req             = 4'b0100;
        wait_grant(cyc);
        check("t1_grant_lat", cyc, 32'd1);
        check("t1_f_thread", {30'd0, f_thread}, 32'd2);
        check("t1_f_addr", f_addr, 32'h1000_0003);
        check("t1_write_mode", {31'd0, write_mode}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_rsp(cyc);
        check("t1_rsp_lat", cyc, 32'd2);
        check("t1_rsp_valid", {28'd0, rsp_valid}, 32'h4);
        check("t1_rsp_data", rsp_data, 32'h0000_00EA);
        check("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("t1_f_enable_low", {31'd0, f_enable}, 32'd0);
        req = 4'd0;
        @(negedge clk);
        check("t1_rsp_pulse", {28'd0, rsp_valid}, 32'd0);
        wait_idle("t1_idle");

        // Reset pulled while waiting for an ack
        fetch_on = 1'b0;
        req      = 4'b0100;
        wait_grant(cyc);
        check("t7_grant_lat", cyc, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("t7_async");
        repeat (2) begin
            @(negedge clk);
            check("t7_no_rsp", {28'd0, rsp_valid}, 32'd0);
        end
        for (int t = 0; t < 4; t++) req_addr[32*t +: 32] = 32'h2000_0000 + t;
        req      = 4'b1111;
        fetch_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesting: strict rotation starting at thread 0
        for (int k = 0; k < 8; k++) begin
            wait_grant(cyc);
            fetch_rdata = 32'h100 + k;
            check($sformatf("t2_grant%0d_thread", k), {30'd0, f_thread}, k % 4);
            check($sformatf("t2_grant%0d_addr", k), f_addr, 32'h2000_0000 + (k % 4));
            wait_rsp(cyc);
            check($sformatf("t2_rsp%0d_valid", k), {28'd0, rsp_valid}, 32'd1 << (k % 4));
            check($sformatf("t2_rsp%0d_data", k), rsp_data, 32'h100 + k);
            check($sformatf("t2_rsp%0d_err", k), {31'd0, rsp_err}, 32'd0);
        end
        req = 4'd0;
        wait_idle("t2_idle");

        // Write from thread 1
        req_we           = 4'b0010;
        req_wdata[63:32] = 32'hCAFE_F00D;
        req_addr[63:32]  = 32'h3000_0010;
        fetch_rdata      = 32'h0000_0055;
        req              = 4'b0010;
        wait_grant(cyc);
        check("t3_f_thread", {30'd0, f_thread}, 32'd1);
        check("t3_write_mode", {31'd0, write_mode}, 32'd1);
        check("t3_f_data_i", f_data_i, 32'hCAFE_F00D);
        check("t3_f_addr", f_addr, 32'h3000_0010);
        wait_rsp(cyc);
        check("t3_rsp_valid", {28'd0, rsp_valid}, 32'h2);
        check("t3_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("t3_rsp_data", rsp_data, 32'h0000_0055);
        req    = 4'd0;
        req_we = 4'd0;
        wait_idle("t3_idle");

        // Timeout: FETCH never acknowledges
        fetch_on          = 1'b0;
        req_addr[127:96]  = 32'h4000_0000;
        req               = 4'b1000;
        wait_grant(cyc);
        check("t4_f_thread", {30'd0, f_thread}, 32'd3);
        wait_rsp(cyc);
        check("t4_rsp_lat", cyc, 32'd4);
        check("t4_rsp_valid", {28'd0, rsp_valid}, 32'h8);
        check("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("t4_rsp_data", rsp_data, 32'd0);
        check("t4_f_enable_low", {31'd0, f_enable}, 32'd0);
        req = 4'd0;
        wait_idle("t4_idle");
        check("t4_f_enable_idle", {31'd0, f_enable}, 32'd0);

        // Ack on the same edge the counter reaches TIMEOUT: success
        fetch_on        = 1'b1;
        ack_lat         = 3;
        fetch_rdata     = 32'h0000_0077;
        req_addr[31:0]  = 32'h5000_0000;
        req             = 4'b0001;
        wait_grant(cyc);
        check("t5_f_thread", {30'd0, f_thread}, 32'd0);
        wait_rsp(cyc);
        check("t5_rsp_lat", cyc, 32'd4);
        check("t5_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        check("t5_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("t5_rsp_data", rsp_data, 32'h0000_0077);
        req     = 4'd0;
        ack_lat = 1;
        wait_idle("t5_idle");

        // Sticky ack holds the arbiter in RELEASE; req stays high to queue a second access
        sticky_len  = 3;
        fetch_rdata = 32'h0000_0099;
        req         = 4'b0001;
        wait_grant(cyc);
        wait_rsp(cyc);
        check("t6_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        check("t6_rsp_data", rsp_data, 32'h0000_0099);
        ack_cycles = 0;
        gap        = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (f_enable) begin
                gap = i;
                break;
            end
            if (f_ack) begin
                ack_cycles++;
                check("t6_release_busy", {31'd0, busy}, 32'd1);
            end
        end
        check("t6_ack_cycles", ack_cycles, 32'd3);
        check("t6_regrant_gap", gap, 32'd6);
        check("t6_regrant_thread", {30'd0, f_thread}, 32'd0);
        wait_rsp(cyc);
        check("t6_rsp2_valid", {28'd0, rsp_valid}, 32'h1);
        req        = 4'd0;
        sticky_len = 0;
        wait_idle("t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
